// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the streaming UART transmitter.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_TX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } uart_state_e;

  localparam logic UART_IDLE_LEVEL  = 1'b1;
  localparam logic UART_START_LEVEL = 1'b0;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Circular byte FIFO feeding the transmitter; no write-to-read bypass.
// Full is reported from the current level, independent of a same-cycle pop.
module uart_tx_fifo
  import uart_tx_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int PTR_W = cnt_w(DEPTH);
  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign full    = (count_q == DEPTH_L);
  assign empty   = (count_q == '0);
  assign level   = count_q;
  assign rd_data = mem_q[rd_ptr_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the level and pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_stream.sv
// UART transmitter draining a word FIFO: start, data LSB first, stop bits.
// Optional parity bit is compiled in with UART_TX_PARITY_EN.
module uart_tx_stream
  import uart_tx_pkg::*;
#(
  parameter int CLK_DIV    = 694,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int DEPTH      = 8,
  parameter int PARITY_ODD = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       io_wr_valid,
  input  logic [DATA_BITS-1:0]       io_wr_data,
  output logic                       io_wr_ready,
  output logic                       io_tx,
  output logic                       io_busy,
  output logic [$clog2(DEPTH+1)-1:0] io_level,
  output logic                       io_frame_done
);

  localparam int CNT_W = cnt_w(CLK_DIV);
  localparam int IDX_W = cnt_w(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

  uart_state_e          state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 bit_end;
  logic                 pop;
  logic                 fifo_full, fifo_empty;
  logic [DATA_BITS-1:0] fifo_rd_data;
`ifdef UART_TX_PARITY_EN
  logic                 par_q, par_d;
`endif

  uart_tx_fifo #(.DEPTH(DEPTH), .WIDTH(DATA_BITS)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (io_wr_valid),
    .wr_data (io_wr_data),
    .pop     (pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (io_level)
  );

  assign io_wr_ready   = !fifo_full;
  assign io_tx         = tx_q;
  assign io_busy       = busy_q;
  assign io_frame_done = done_q;
  assign bit_end       = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    if (state_q != ST_IDLE) cnt_d = bit_end ? CNT_LOAD : cnt_q - 1'b1;

    case (state_q)
      ST_IDLE: if (!fifo_empty) begin
        pop     = 1'b1;
        state_d = ST_START;
        cnt_d   = CNT_LOAD;
      end
      ST_START: if (bit_end) begin
        state_d = ST_DATA;
        idx_d   = '0;
      end
      ST_DATA: if (bit_end) begin
        shift_d = shift_q >> 1;
        if (idx_q == DATA_LAST) begin
          idx_d = '0;
`ifdef UART_TX_PARITY_EN
          state_d = ST_PARITY;
`else
          state_d = ST_STOP;
`endif
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: if (bit_end) begin
        state_d = ST_STOP;
        idx_d   = '0;
      end
`endif
      ST_STOP: if (bit_end) begin
        if (idx_q == STOP_LAST) begin
          // Chain straight into the next frame when a word is waiting.
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (pop) begin
      shift_d = fifo_rd_data;
`ifdef UART_TX_PARITY_EN
      par_d   = (^fifo_rd_data) ^ 1'(PARITY_ODD);
`endif
    end

    // Outputs are registered from the next-state view so they align with state_q.
    case (state_d)
      ST_START:  tx_d = UART_START_LEVEL;
      ST_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_d = par_d;
`endif
      default:   tx_d = UART_IDLE_LEVEL;
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_STOP) && (cnt_d == '0) && (idx_d == STOP_LAST);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= UART_IDLE_LEVEL;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: doc/uart_tx_stream.md
# uart_tx_stream

Parametrised UART transmitter with a byte FIFO. It serialises queued words onto a single line as start, data (LSB first), optional parity and stop bits, with an exact per-bit cycle count. It replaces hand-timed serial stimulus: benches and on-chip loopback paths feed the Patmos `io_uartPins_rx` pin from this block. Word width, stop-bit count, FIFO depth and bit period are all configurable.

## Interface
- `CLK_DIV`, 694: clock cycles per bit. 80 MHz / 115200 baud. Legal range ≥ 2.
- `DATA_BITS`, 8: data bits per frame, 5..9.
- `STOP_BITS`, 1: stop bits per frame, 1 or 2.
- `DEPTH`, 8: FIFO entries, power of two ≥ 2.
- `PARITY_ODD`, 0: 1 = odd parity, 0 = even. Used only with the parity macro.
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high reset.
- `io_wr_valid` in 1: push request.
- `io_wr_data` in DATA_BITS: word to push.
- `io_wr_ready` out 1: FIFO not full. A push occurs when valid && ready.
- `io_tx` out 1: serial line. Idles high.
- `io_busy` out 1: a frame is in progress (state ≠ IDLE).
- `io_level` out $clog2(DEPTH+1): FIFO occupancy.
- `io_frame_done` out 1: one-cycle pulse in the last cycle of the last stop bit.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- Bit counter: `bit_cnt` counts CLK_DIV-1 down to 0. It reloads on every bit boundary, so every bit lasts exactly CLK_DIV cycles.
- IDLE:
  - `io_tx`=1.
  - If the FIFO is non-empty, pop the head into the shift register and go to START.
- START: `io_tx`=0 for one bit, then go to DATA.
- DATA:
  - `io_tx`=shift[0]; shift right at each bit boundary.
  - After DATA_BITS bits, go to PARITY (macro on) or STOP.
- PARITY: `io_tx` = XOR of the data bits, XORed with PARITY_ODD.
- STOP:
  - `io_tx`=1 for STOP_BITS bits.
  - In the final cycle: pulse `io_frame_done`.
  - If the FIFO is non-empty, pop and go directly to START (no idle gap). Otherwise go to IDLE.
- FIFO:
  - Circular buffer with wrapping read and write pointers.
  - `io_wr_ready` = !full, independent of a same-cycle pop.
  - A push while full is ignored.
  - No bypass: a word pushed into an empty FIFO becomes visible to the FSM the next cycle.
  - A simultaneous push and pop leaves the level unchanged.
- Reset values:
  - `io_tx`=1, `io_busy`=0, `io_level`=0, `io_wr_ready`=1, `io_frame_done`=0.
  - State IDLE, pointers 0.
- Reset mid-frame: the line returns high immediately (asynchronously). The frame is abandoned and the FIFO contents are discarded.

## Timing
- Push at cycle t with FIFO empty and FSM idle:
  - t+1: `io_level`=1.
  - t+1: pop, so `io_level`=0 and state START from t+2.
  - `io_tx` falls at t+2.
- Frame length = (1 + DATA_BITS + P + STOP_BITS) × CLK_DIV cycles, where P = 1 with parity, 0 without.
- Back-to-back frames with no idle cycles while the FIFO stays non-empty.
- `io_busy` rises with START and falls the cycle after the last stop bit if no word is queued.
- All outputs are registered. `io_tx` comes straight from a flop (glitch-free).

## Configuration
- `UART_TX_PARITY_EN`:
  - Defined: PARITY state compiled in; one parity bit after the data, polarity from PARITY_ODD.
  - Undefined: PARITY state and its logic absent; PARITY_ODD ignored; DATA goes directly to STOP.

## Structure
- Package `uart_tx_pkg`:
  - State enum.
  - `UART_IDLE_LEVEL`=1'b1 and `UART_START_LEVEL`=1'b0 constants.
  - Width helper function for the counter widths.
- Sub-module `uart_tx_fifo`: DEPTH × DATA_BITS with push/pop/full/empty/level. The FSM, bit counter and shift register stay in the top.

## Test plan
- **Single frame:** defaults, no parity; push 0xAB at t.
  - `io_tx` from t+2 = 0,1,1,0,1,0,1,0,1,1, each bit 694 cycles.
  - `io_frame_done` pulses at cycle t+2+6939.
  - Line high afterwards.
- **Parity:** macro on, PARITY_ODD=0, push 0xAB → parity bit 1; frame 7634 cycles. With PARITY_ODD=1 → parity bit 0.
- **Full FIFO:** DEPTH=4, CLK_DIV=4.
  - Push 6 words on consecutive cycles: words 0–4 accepted (one popped early), `io_wr_ready`=0 while `io_level`=4, word 5 dropped.
  - 5 frames transmitted back-to-back with no high gap between stop and start.
- **Two stop bits:** STOP_BITS=2, DATA_BITS=7, push 0x55 → frame 10 × CLK_DIV cycles with 2 × CLK_DIV high at the end.
- **Reset mid-frame:** assert reset during DATA bit 3 → `io_tx`=1 in the same cycle, `io_level`=0, `io_busy`=0; next push produces a clean frame.
- **Simultaneous push/pop:** push on the STOP final cycle with 1 queued word → `io_level` stays 1, next START begins the following cycle.
